// File: rtl/trees_ctrl_pkg.sv
// rtl/trees_ctrl_pkg.sv - shared types, constants and helpers for the tree batch sequencer
package trees_ctrl_pkg;

   localparam logic BANK_PING = 1'b1;

   typedef enum logic [1:0] {L_IDLE, L_FILL, L_WAIT} load_state_t;
   typedef enum logic [1:0] {E_IDLE, E_ARM, E_RUN, E_DRAIN} exec_state_t;

   // Eight 8-bit predictions are packed per 64-bit word.
   function automatic logic [31:0] pred_words(input logic [31:0] burst_len);
      return (burst_len + 32'd7) >> 3;
   endfunction

endpackage

// File: rtl/trees_feature_loader.sv
// rtl/trees_feature_loader.sv - streams feature words into alternating ping/pong banks
module trees_feature_loader
   import trees_ctrl_pkg::*;
#(
   parameter int WPS  = 16,
   parameter int BL_W = 14,
   parameter int NB_W = 17,
   parameter int FA_W = 17
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            job_go,
   input  logic [BL_W-1:0] burst_len,
   input  logic [NB_W-1:0] n_batches,
   input  logic [1:0]      bank_full,
   input  logic            exec_idle,
   input  logic            s_valid,
   input  logic [63:0]     s_data,
   output logic            s_ready,
   output logic            acc_load_features,
   output logic            acc_m_ping_pong,
   output logic [FA_W-1:0] acc_feature_addr,
   output logic [63:0]     acc_features2,
   output logic [1:0]      bank_set,
   output logic            loader_idle
);

   load_state_t     state;
   logic            lb;
   logic [FA_W-1:0] wcnt;
   logic [FA_W-1:0] wpb_last;
   logic [NB_W-1:0] loaded;
   logic            hs;
   logic            last_word;

   assign wpb_last    = FA_W'(burst_len) * FA_W'(WPS) - FA_W'(1);
   assign s_ready     = (state == L_FILL) && !bank_full[lb];
   assign hs          = s_valid && s_ready;
   assign last_word   = hs && (wcnt == wpb_last);
   // Bank becomes full on the same edge that raises the final write strobe.
   assign bank_set    = last_word ? (lb ? 2'b10 : 2'b01) : 2'b00;
   assign loader_idle = (state == L_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= L_IDLE;
         lb                <= BANK_PING;
         wcnt              <= '0;
         loaded            <= '0;
         acc_load_features <= 1'b0;
         acc_m_ping_pong   <= BANK_PING;
         acc_feature_addr  <= '0;
         acc_features2     <= '0;
      end else begin
         acc_load_features <= hs;
         if (hs) begin
            acc_m_ping_pong  <= lb;
            acc_feature_addr <= wcnt;
            acc_features2    <= s_data;
         end
         case (state)
            L_IDLE: begin
               if (job_go) begin
                  lb     <= BANK_PING;
                  wcnt   <= '0;
                  loaded <= '0;
                  state  <= L_FILL;
               end
            end
            L_FILL: begin
               if (hs) begin
                  if (last_word) begin
                     wcnt   <= '0;
                     lb     <= !lb;
                     loaded <= loaded + NB_W'(1);
                     if (loaded + NB_W'(1) == n_batches)
                        state <= L_WAIT;
                  end else begin
                     wcnt <= wcnt + FA_W'(1);
                  end
               end
            end
            L_WAIT: begin
               if (exec_idle)
                  state <= L_IDLE;
            end
            default: state <= L_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/trees_batch_ctrl.sv
// rtl/trees_batch_ctrl.sv - ping-pong batch sequencer: load, start, wait, drain predictions
module trees_batch_ctrl
   import trees_ctrl_pkg::*;
#(
   parameter int N_FEATURE   = 32,
   parameter int MAX_BURST   = 5000,
   parameter int MAX_BATCHES = 65535,
   localparam int BL_W = $clog2(MAX_BURST) + 1,
   localparam int NB_W = $clog2(MAX_BATCHES) + 1,
   localparam int FA_W = $clog2(MAX_BURST * N_FEATURE / 2),
   localparam int PA_W = $clog2(MAX_BURST) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            job_start,
   input  logic [BL_W-1:0] cfg_burst_len,
   input  logic [NB_W-1:0] cfg_n_batches,
   output logic            job_idle,
   output logic            job_done,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [63:0]     s_data,
   output logic            acc_start,
   input  logic            acc_idle,
   input  logic            acc_done,
   output logic            acc_m_ping_pong,
   output logic            acc_e_ping_pong,
   output logic            acc_load_features,
   output logic [FA_W-1:0] acc_feature_addr,
   output logic [63:0]     acc_features2,
   output logic [BL_W-1:0] acc_burst_len,
   output logic [PA_W-1:0] acc_prediction_addr,
   input  logic [63:0]     acc_prediction,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [63:0]     m_data,
   output logic            m_last
);

   exec_state_t     estate;
   logic            eb;
   logic [BL_W-1:0] burst_len;
   logic [NB_W-1:0] n_batches;
   logic [NB_W-1:0] drained;
   logic [1:0]      bank_full;
   logic [1:0]      bank_set;
   logic [1:0]      bank_clr;
   logic [PA_W-1:0] pw;
   logic            job_go;
   logic            loader_idle;
   logic            m_hs;
   logic            at_last_word;
   logic            last_batch;
   logic            drain_end;

   assign job_idle      = loader_idle && (estate == E_IDLE);
   assign job_go        = job_start && job_idle;
   assign pw            = PA_W'(pred_words(32'(burst_len)));
   assign acc_burst_len = burst_len;
   assign m_data        = acc_prediction;
   assign m_hs          = m_valid && m_ready;
   assign at_last_word  = (acc_prediction_addr == pw - PA_W'(1));
   assign last_batch    = (drained + NB_W'(1) == n_batches);
   assign drain_end     = m_hs && at_last_word;
   assign m_last        = m_valid && last_batch && at_last_word;
   assign bank_clr      = drain_end ? (eb ? 2'b10 : 2'b01) : 2'b00;

   trees_feature_loader #(
      .WPS  (N_FEATURE / 2),
      .BL_W (BL_W),
      .NB_W (NB_W),
      .FA_W (FA_W)
   ) u_loader (
      .clk               (clk),
      .rst_n             (rst_n),
      .job_go            (job_go),
      .burst_len         (burst_len),
      .n_batches         (n_batches),
      .bank_full         (bank_full),
      .exec_idle         (estate == E_IDLE),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .acc_load_features (acc_load_features),
      .acc_m_ping_pong   (acc_m_ping_pong),
      .acc_feature_addr  (acc_feature_addr),
      .acc_features2     (acc_features2),
      .bank_set          (bank_set),
      .loader_idle       (loader_idle)
   );

   // Set and clear always target different banks, so both apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full <= 2'b00;
         burst_len <= '0;
         n_batches <= '0;
      end else begin
         bank_full <= (bank_full | bank_set) & ~bank_clr;
         if (job_go) begin
            burst_len <= cfg_burst_len;
            n_batches <= cfg_n_batches;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estate              <= E_IDLE;
         eb                  <= BANK_PING;
         drained             <= '0;
         acc_start           <= 1'b0;
         acc_e_ping_pong     <= BANK_PING;
         acc_prediction_addr <= '0;
         m_valid             <= 1'b0;
         job_done            <= 1'b0;
      end else begin
         acc_start <= 1'b0;
         job_done  <= 1'b0;
         case (estate)
            E_IDLE: begin
               if (job_go) begin
                  eb      <= BANK_PING;
                  drained <= '0;
                  estate  <= E_ARM;
               end
            end
            E_ARM: begin
               // bank_full is seen a cycle after it is set, giving the last write time to land.
               if (bank_full[eb] && acc_idle) begin
                  acc_start       <= 1'b1;
                  acc_e_ping_pong <= eb;
                  estate          <= E_RUN;
               end
            end
            E_RUN: begin
               if (acc_done) begin
                  acc_prediction_addr <= '0;
                  m_valid             <= 1'b1;
                  estate              <= E_DRAIN;
               end
            end
            E_DRAIN: begin
               if (m_hs) begin
                  if (at_last_word) begin
                     m_valid             <= 1'b0;
                     acc_prediction_addr <= '0;
                     eb                  <= !eb;
                     drained             <= drained + NB_W'(1);
                     if (last_batch) begin
                        job_done <= 1'b1;
                        estate   <= E_IDLE;
                     end else begin
                        estate <= E_ARM;
                     end
                  end else begin
                     acc_prediction_addr <= acc_prediction_addr + PA_W'(1);
                  end
               end
            end
            default: estate <= E_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trees_batch_ctrl.sv
// tb/tb_trees_batch_ctrl.sv - scoreboard bench with an accelerator model for trees_batch_ctrl
module tb_trees_batch_ctrl;

   localparam int BL_W = 14;
   localparam int NB_W = 17;
   localparam int FA_W = 17;
   localparam int PA_W = 14;
   localparam int WPS  = 16;

   logic            clk;
   logic            rst_n;
   logic            job_start;
   logic [BL_W-1:0] cfg_burst_len;
   logic [NB_W-1:0] cfg_n_batches;
   logic            job_idle;
   logic            job_done;
   logic            s_valid;
   logic            s_ready;
   logic [63:0]     s_data;
   logic            acc_start;
   logic            acc_idle;
   logic            acc_done;
   logic            acc_m_ping_pong;
   logic            acc_e_ping_pong;
   logic            acc_load_features;
   logic [FA_W-1:0] acc_feature_addr;
   logic [63:0]     acc_features2;
   logic [BL_W-1:0] acc_burst_len;
   logic [PA_W-1:0] acc_prediction_addr;
   logic [63:0]     acc_prediction;
   logic            m_valid;
   logic            m_ready;
   logic [63:0]     m_data;
   logic            m_last;

   trees_batch_ctrl dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .job_start           (job_start),
      .cfg_burst_len       (cfg_burst_len),
      .cfg_n_batches       (cfg_n_batches),
      .job_idle            (job_idle),
      .job_done            (job_done),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .s_data              (s_data),
      .acc_start           (acc_start),
      .acc_idle            (acc_idle),
      .acc_done            (acc_done),
      .acc_m_ping_pong     (acc_m_ping_pong),
      .acc_e_ping_pong     (acc_e_ping_pong),
      .acc_load_features   (acc_load_features),
      .acc_feature_addr    (acc_feature_addr),
      .acc_features2       (acc_features2),
      .acc_burst_len       (acc_burst_len),
      .acc_prediction_addr (acc_prediction_addr),
      .acc_prediction      (acc_prediction),
      .m_valid             (m_valid),
      .m_ready             (m_ready),
      .m_data              (m_data),
      .m_last              (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {logic bank; int addr; logic [63:0] data;} wr_t;
   typedef struct {logic [63:0] data; logic last;} out_t;

   wr_t          wq[$];
   out_t         oq[$];
   logic [63:0]  stream[$];
   logic [63:0]  bank_mem [0:1][0:1023];
   logic [7:0]   pred_bytes [0:255];

   int n_chk = 0;
   int n_pass = 0;
   int cur_bl = 1;
   int cur_pw = 1;
   int starts = 0;
   int words_drained = 0;
   int writes_seen = 0;
   int done_cnt = 0;
   int acc_dmin = 2;
   int acc_dmax = 8;
   int ready_mode = 1;
   bit hold_valid = 0;
   bit abort = 0;

   function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endfunction

   // Prediction of one sample: byte-wise sum of all its feature words.
   function automatic logic [7:0] ref_byte(input int b, input int s);
      logic [7:0]  sum = 8'h00;
      logic [63:0] w;
      for (int k = 0; k < WPS; k++) begin
         w = stream[(b * cur_bl + s) * WPS + k];
         for (int j = 0; j < 8; j++) sum += w[8*j +: 8];
      end
      return sum;
   endfunction

   always_comb begin
      acc_prediction = 64'h0;
      for (int j = 0; j < 8; j++) begin
         if (int'(acc_prediction_addr) * 8 + j < 256)
            acc_prediction[8*j +: 8] = pred_bytes[int'(acc_prediction_addr) * 8 + j];
      end
   end

   // Accelerator model: computes predictions from its bank memory on start.
   initial begin
      int d;
      logic [7:0] sum;
      logic [63:0] w;
      acc_idle = 1'b1;
      acc_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && acc_start) begin
            chk(acc_e_ping_pong == ((starts % 2 == 0) ? 1'b1 : 1'b0), "start_bank", 64'(acc_e_ping_pong), 64'((starts % 2 == 0) ? 1 : 0));
            chk(words_drained == starts * cur_pw, "start_after_drain", 64'(words_drained), 64'(starts * cur_pw));
            chk(writes_seen >= (starts + 1) * cur_bl * WPS, "start_after_load", 64'(writes_seen), 64'((starts + 1) * cur_bl * WPS));
            for (int s = 0; s < 256; s++) begin
               sum = 8'h00;
               if (s < cur_bl) begin
                  for (int k = 0; k < WPS; k++) begin
                     w = bank_mem[acc_e_ping_pong][s * WPS + k];
                     for (int j = 0; j < 8; j++) sum += w[8*j +: 8];
                  end
               end
               pred_bytes[s] = sum;
            end
            starts++;
            acc_idle = 1'b0;
            d = $urandom_range(acc_dmin, acc_dmax);
            repeat (d) @(posedge clk);
            #1 acc_done = 1'b1;
            @(posedge clk);
            #1 acc_done = 1'b0;
            acc_idle = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && acc_load_features) begin
         writes_seen++;
         if (wq.size() == 0) begin
            chk(1'b0, "unexpected_write", 64'(acc_feature_addr), 64'h0);
         end else begin
            wr_t e;
            e = wq.pop_front();
            chk(acc_m_ping_pong == e.bank, "write_bank", 64'(acc_m_ping_pong), 64'(e.bank));
            chk(int'(acc_feature_addr) == e.addr, "write_addr", 64'(acc_feature_addr), 64'(e.addr));
            chk(acc_features2 == e.data, "write_data", acc_features2, e.data);
            if (acc_feature_addr < 1024) bank_mem[acc_m_ping_pong][acc_feature_addr] = acc_features2;
         end
      end
   end

   logic            prev_stall = 1'b0;
   logic            prev_hs = 1'b0;
   logic            prev_last_of_batch = 1'b0;
   logic [63:0]     prev_data;
   logic [PA_W-1:0] prev_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (job_done) done_cnt++;
         if (prev_stall) begin
            chk(m_valid == 1'b1, "stall_valid_held", 64'(m_valid), 64'h1);
            chk(m_data == prev_data, "stall_data_held", m_data, prev_data);
            chk(acc_prediction_addr == prev_addr, "stall_addr_held", 64'(acc_prediction_addr), 64'(prev_addr));
         end
         if (prev_hs && !prev_last_of_batch)
            chk(acc_prediction_addr == prev_addr + PA_W'(1), "addr_advance", 64'(acc_prediction_addr), 64'(prev_addr + PA_W'(1)));
         prev_last_of_batch = 1'b0;
         if (m_valid && m_ready) begin
            if (oq.size() == 0) begin
               chk(1'b0, "unexpected_output", m_data, 64'h0);
            end else begin
               out_t e;
               e = oq.pop_front();
               chk(m_data == e.data, "m_data", m_data, e.data);
               chk(m_last == e.last, "m_last", 64'(m_last), 64'(e.last));
            end
            words_drained++;
            prev_last_of_batch = (words_drained % cur_pw == 0);
         end
         prev_stall = m_valid && !m_ready;
         prev_hs    = m_valid && m_ready;
         prev_data  = m_data;
         prev_addr  = acc_prediction_addr;
      end
   end

   initial begin
      logic [3:0] pat = 4'b1001;
      int ph = 0;
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: m_ready = 1'($urandom_range(0, 1));
            2: begin m_ready = pat[3 - ph]; ph = (ph + 1) % 4; end
            default: m_ready = 1'b1;
         endcase
      end
   end

   task automatic do_stream();
      int i = 0;
      int guard = 0;
      int wpb = cur_bl * WPS;
      while (i < stream.size() && !abort && guard < 20000) begin
         if (!hold_valid && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = stream[i];
         end
         @(negedge clk);
         if (s_valid && s_ready && rst_n) begin
            wq.push_back(wr_t'{((i / wpb) % 2 == 0), i % wpb, stream[i]});
            i++;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      s_valid = 1'b0;
   endtask

   task automatic setup_job(input int bl, input int nb);
      out_t e;
      cur_bl = bl;
      cur_pw = (bl + 7) / 8;
      starts = 0;
      words_drained = 0;
      writes_seen = 0;
      done_cnt = 0;
      stream.delete();
      for (int k = 0; k < bl * nb * WPS; k++) stream.push_back({$urandom, $urandom});
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < cur_pw; k++) begin
            e.data = 64'h0;
            for (int j = 0; j < 8; j++)
               if (8 * k + j < bl) e.data[8*j +: 8] = ref_byte(b, 8 * k + j);
            e.last = (b == nb - 1) && (k == cur_pw - 1);
            oq.push_back(e);
         end
      end
      cfg_burst_len = BL_W'(bl);
      cfg_n_batches = NB_W'(nb);
      job_start = 1'b1;
      @(posedge clk);
      #1 job_start = 1'b0;
   endtask

   task automatic finish_job(input int nb);
      int guard = 0;
      while (done_cnt == 0 && guard < 8000) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(done_cnt == 1, "job_done_pulses", 64'(done_cnt), 64'h1);
      chk(oq.size() == 0, "outputs_left", 64'(oq.size()), 64'h0);
      chk(wq.size() == 0, "writes_left", 64'(wq.size()), 64'h0);
      chk(starts == nb, "start_count", 64'(starts), 64'(nb));
      chk(job_idle == 1'b1, "idle_after_job", 64'(job_idle), 64'h1);
   endtask

   task automatic run_job(input int bl, input int nb, input int dmin, input int dmax, input int rmode);
      acc_dmin = dmin;
      acc_dmax = dmax;
      ready_mode = rmode;
      hold_valid = 0;
      setup_job(bl, nb);
      do_stream();
      finish_job(nb);
   endtask

   task automatic check_reset(input string tag);
      chk(job_idle == 1'b1, {tag, "_job_idle"}, 64'(job_idle), 64'h1);
      chk(job_done == 1'b0, {tag, "_job_done"}, 64'(job_done), 64'h0);
      chk(s_ready == 1'b0, {tag, "_s_ready"}, 64'(s_ready), 64'h0);
      chk(acc_start == 1'b0, {tag, "_acc_start"}, 64'(acc_start), 64'h0);
      chk(acc_m_ping_pong == 1'b1, {tag, "_m_ping_pong"}, 64'(acc_m_ping_pong), 64'h1);
      chk(acc_e_ping_pong == 1'b1, {tag, "_e_ping_pong"}, 64'(acc_e_ping_pong), 64'h1);
      chk(acc_load_features == 1'b0, {tag, "_load"}, 64'(acc_load_features), 64'h0);
      chk(acc_feature_addr == '0, {tag, "_feature_addr"}, 64'(acc_feature_addr), 64'h0);
      chk(acc_features2 == 64'h0, {tag, "_features2"}, acc_features2, 64'h0);
      chk(acc_prediction_addr == '0, {tag, "_pred_addr"}, 64'(acc_prediction_addr), 64'h0);
      chk(m_valid == 1'b0, {tag, "_m_valid"}, 64'(m_valid), 64'h0);
      chk(m_last == 1'b0, {tag, "_m_last"}, 64'(m_last), 64'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      job_start = 1'b0;
      cfg_burst_len = '0;
      cfg_n_batches = '0;
      s_valid = 1'b0;
      s_data = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_job(1, 1, 3, 6, 1);
      run_job(9, 3, 5, 30, 0);
      run_job(17, 2, 2, 10, 2);

      // Both banks full with batch 0 still running: loader must hold off.
      acc_dmin = 150;
      acc_dmax = 150;
      ready_mode = 1;
      hold_valid = 1;
      setup_job(1, 4);
      fork
         do_stream();
         begin
            int g = 0;
            logic [FA_W-1:0] a0;
            while (starts < 1 && g < 2000) begin @(posedge clk); g++; end
            chk(starts >= 1, "stall_first_start", 64'(starts), 64'h1);
            repeat (60) @(posedge clk);
            #1;
            cfg_burst_len = BL_W'(7);
            cfg_n_batches = NB_W'(9);
            job_start = 1'b1;
            @(posedge clk);
            #1 job_start = 1'b0;
            @(negedge clk);
            a0 = acc_feature_addr;
            chk(writes_seen == 32, "overlap_writes", 64'(writes_seen), 64'd32);
            chk(acc_e_ping_pong == 1'b1, "exec_bank_held", 64'(acc_e_ping_pong), 64'h1);
            chk(a0 == FA_W'(15), "stall_last_addr", 64'(a0), 64'd15);
            repeat (6) begin
               @(negedge clk);
               chk(!s_ready && s_valid, "stall_s_ready", 64'(s_ready), 64'h0);
               chk(acc_feature_addr == a0 && !acc_load_features, "stall_no_write", 64'(acc_feature_addr), 64'(a0));
            end
            chk(acc_burst_len == BL_W'(1), "start_ignored", 64'(acc_burst_len), 64'h1);
         end
      join
      finish_job(4);
      hold_valid = 0;

      for (int r = 0; r < 4; r++)
         run_job($urandom_range(1, 24), $urandom_range(1, 4), 1, 20, 0);

      // Reset in the middle of a run, then a clean job from ping.
      acc_dmin = 40;
      acc_dmax = 40;
      ready_mode = 1;
      setup_job(9, 3);
      fork
         do_stream();
         begin
            int g = 0;
            while (starts < 1 && g < 2000) begin @(posedge clk); g++; end
            chk(starts >= 1, "abort_run_reached", 64'(starts), 64'h1);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b0;
            abort = 1;
            #1;
            check_reset("abort");
         end
      join
      wq.delete();
      oq.delete();
      begin
         int g = 0;
         while (!acc_idle && g < 500) begin @(posedge clk); g++; end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      abort = 0;
      @(posedge clk);
      #1;
      run_job(9, 2, 2, 8, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/trees_batch_ctrl.md
Name: trees_batch_ctrl

Overview:
- Host-side sequencer in front of the ping-pong tree-ensemble accelerator.
- Accepts a stream of 64-bit feature words (two 32-bit features per word) for `n_batches` batches of `burst_len` samples each.
- Fills the two feature banks alternately; while one batch executes, the next batch loads into the other bank.
- Issues start, waits for done, then drains packed 8-bit predictions (8 per 64-bit word) to an output stream.

Parameters:
- N_FEATURE, 32, features per sample; words per sample WPS = N_FEATURE/2.
- MAX_BURST, 5000, maximum samples per batch.
- MAX_BATCHES, 65535, maximum batches per job.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- job_start  in  1  one-cycle pulse; samples cfg_burst_len and cfg_n_batches; ignored unless job_idle.
- cfg_burst_len  in  $clog2(MAX_BURST)+1  samples per batch, 1..MAX_BURST.
- cfg_n_batches  in  $clog2(MAX_BATCHES)+1  batches per job, >=1.
- job_idle  out  1  high when no job is active.
- job_done  out  1  one-cycle pulse after the last prediction word is accepted.
- s_valid  in  1  feature word valid.
- s_ready  out  1  feature word accepted when s_valid&&s_ready.
- s_data  in  64  feature word.
- acc_start  out  1  one-cycle start pulse to the accelerator.
- acc_idle  in  1  accelerator idle.
- acc_done  in  1  accelerator batch-done pulse.
- acc_m_ping_pong  out  1  write bank select (1 ping, 0 pong).
- acc_e_ping_pong  out  1  execute bank select (1 ping, 0 pong).
- acc_load_features  out  1  feature write strobe.
- acc_feature_addr  out  $clog2(MAX_BURST*N_FEATURE/2)  feature word address within the bank.
- acc_features2  out  64  feature word (registered copy of s_data).
- acc_burst_len  out  $clog2(MAX_BURST)+1  equals the latched burst_len.
- acc_prediction_addr  out  $clog2(MAX_BURST)+1  prediction word index.
- acc_prediction  in  64  prediction word, combinational from acc_prediction_addr.
- m_valid  out  1  prediction word valid.
- m_ready  in  1  downstream ready.
- m_data  out  64  prediction word.
- m_last  out  1  last word of the last batch.

Behaviour:
- Reset values:
  - Asserted: job_idle=1, acc_m_ping_pong=1, acc_e_ping_pong=1.
  - Zero: job_done, s_ready, acc_start, acc_load_features, acc_feature_addr, acc_features2, acc_prediction_addr, m_valid, m_last.
  - bank_full[1:0]=0.
- Reset mid-job aborts immediately; no partial state survives.
- Derived values:
  - WPB = burst_len*WPS, the words per batch.
  - PW = (burst_len+7)>>3, the prediction words per batch, so burst_len=9 gives 2.
- Loader FSM, states L_IDLE, L_FILL, L_WAIT:
  - L_IDLE: on job_start, latch the config, set bank pointer lb=ping, then go to L_FILL.
  - L_FILL: s_ready=!bank_full[lb].
    - Each handshake registers a write one cycle later: acc_load_features=1, acc_m_ping_pong=lb, acc_feature_addr=word count, acc_features2=s_data.
    - The word count wraps to 0 at WPB-1.
    - At the last word: set bank_full[lb] in the same cycle as the final write strobe, toggle lb, and increment the loaded-batch count.
    - After loading n_batches, go to L_WAIT with s_ready=0.
  - L_WAIT: return to L_IDLE when the exec FSM returns to idle.
- Exec FSM, states E_IDLE, E_ARM, E_RUN, E_DRAIN:
  - E_IDLE: on job_start, set eb=ping, then go to E_ARM.
  - E_ARM: when bank_full[eb] && acc_idle, drive acc_e_ping_pong=eb and pulse acc_start for 1 cycle, then go to E_RUN.
    - The bank_full set and acc_start are never in the same cycle; one cycle of write settling is required.
  - E_RUN: wait for acc_done.
    - acc_e_ping_pong is held stable from E_ARM until leaving E_DRAIN.
    - On acc_done, set acc_prediction_addr=0 and go to E_DRAIN.
  - E_DRAIN: m_valid=1, m_data=acc_prediction.
    - Each handshake increments the address.
    - After PW words: clear bank_full[eb] and toggle eb.
    - If more batches remain, go to E_ARM; otherwise pulse job_done and go to E_IDLE.
    - m_last=1 on the final word of the final batch only.
- Ordering:
  - The next acc_start is never issued before the previous drain completes, because the accelerator prediction memory is single-buffered.
  - Loading of the other bank proceeds during E_RUN and E_DRAIN.
- Simultaneous events:
  - bank_full set by the loader and cleared by exec in the same cycle always target different banks. Both take effect.
  - job_start while !job_idle is ignored.
  - acc_done outside E_RUN is ignored.
- m_valid/m_data are held stable while m_valid && !m_ready.

Decomposition:
- Package trees_ctrl_pkg holds:
  - the typedefs load_state_t {L_IDLE,L_FILL,L_WAIT} and exec_state_t {E_IDLE,E_ARM,E_RUN,E_DRAIN};
  - the constant BANK_PING=1'b1;
  - the function pred_words(burst_len).
- Natural sub-module: trees_feature_loader, containing the loader FSM, word counter and write-port register.
- The exec FSM and drain logic stay in the top module.

Test Plan:
- burst_len=1, n_batches=1, 16 words streamed -> 16 writes to ping at addr 0..15, one acc_start with e=1, one m_data word with m_last=1, then job_done.
- burst_len=9, n_batches=3 -> banks used in order ping/pong/ping, 2 prediction words per batch, 6 words total, m_last on word 6 only.
- Second batch streamed during batch-1 E_RUN -> pong writes overlap the run; acc_e_ping_pong stays 1 until batch-1 drain ends.
- Both banks full and exec stalled -> s_ready=0; word count and addresses are unchanged while s_valid is held high.
- m_ready toggled 1,0,0,1 during drain -> m_data is stable while stalled and acc_prediction_addr advances only on handshakes.
- rst_n asserted mid-E_RUN -> all outputs return to reset values the same cycle; a new job_start runs cleanly from ping.
